// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the multi-cycle divider
//
// Purpose: state encoding, default widths and fixed result constants used by
// mdu_divider, its interface and its iteration sub-module.
// Ports: none (package).
package mdu_pkg;

  localparam int DIV_W_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 6;
  localparam int RESULT_W      = 2 * DIV_W_DEFAULT;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_W_DEFAULT-1:0] DZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/mdu_divider_if.sv
// rtl/mdu_divider_if.sv - EX-stage to divider handshake bundle
//
// Purpose: groups the operand/control inputs and result/stall outputs of the
// divider so the EX stage and the divider connect through one port.
// Ports (modport slave = divider side):
//   start_i, signed_i, a_i, b_i, hold_i, annul_i : into the divider
//   result_o, ready_o, div_stall_o, busy_o       : out of the divider
interface mdu_divider_if
  import mdu_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
);

  logic               start_i;
  logic               signed_i;
  logic [DIV_W-1:0]   a_i;
  logic [DIV_W-1:0]   b_i;
  logic               hold_i;
  logic               annul_i;
  logic [2*DIV_W-1:0] result_o;
  logic               ready_o;
  logic               div_stall_o;
  logic               busy_o;

  modport master (
    output start_i, signed_i, a_i, b_i, hold_i, annul_i,
    input  result_o, ready_o, div_stall_o, busy_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, hold_i, annul_i,
    output result_o, ready_o, div_stall_o, busy_o
  );

endinterface

// File: rtl/div_radix2_step.sv
// rtl/div_radix2_step.sv - one restoring radix-2 division iteration
//
// Purpose: shift {rem, quot} left by one, trial-subtract the divisor and set
// the new quotient bit when the difference is non-negative. Purely
// combinational.
// Ports:
//   rem, quot        : current partial remainder / quotient shift register
//   divisor          : unsigned divisor magnitude
//   rem_next, quot_next : values after this iteration
module div_radix2_step #(
  parameter int DIV_W = 32
) (
  input  logic [DIV_W-1:0] rem,
  input  logic [DIV_W-1:0] quot,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_next,
  output logic [DIV_W-1:0] quot_next
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [DIV_W:0] shifted;
  logic [DIV_W:0] diff;
  logic           fits;

  always_comb begin
    shifted   = {rem, quot[DIV_W-1]};
    diff      = shifted - {1'b0, divisor};
    fits      = ~diff[DIV_W];
    rem_next  = fits ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
    quot_next = {quot[DIV_W-2:0], fits};
  end

endmodule

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - multi-cycle DIV/DIVU unit for the EX stage
//
// Purpose: restoring radix-2 divider, one quotient bit per cycle. Raises
// div_stall_o while the operation is in flight and presents
// {remainder, quotient} on result_o with ready_o once done.
// Optional build macro: MDU_DIV_EARLY_OUT_EN (finish in one cycle when the
// dividend magnitude is below a non-zero divisor magnitude).
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : mdu_divider_if.slave (start/signed/a/b/hold/annul in,
//            result/ready/div_stall/busy out)
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  mdu_divider_if.slave  bus
);

  div_state_e state, state_next;

  logic [CNT_W-1:0]   cnt;
  logic [DIV_W-1:0]   rem, quot, dvsr, a_raw;
  logic               sign_q, sign_r, is_signed, div_zero;
  logic [2*DIV_W-1:0] result;

  logic [DIV_W-1:0]   a_mag, b_mag;
  logic [DIV_W-1:0]   rem_step, quot_step;
  logic [DIV_W-1:0]   q_fix, r_fix;
  logic               accept, last_step, early_out;

  // Magnitudes only differ from the raw operands for signed negatives.
  always_comb begin
    a_mag     = (bus.signed_i && bus.a_i[DIV_W-1]) ? -bus.a_i : bus.a_i;
    b_mag     = (bus.signed_i && bus.b_i[DIV_W-1]) ? -bus.b_i : bus.b_i;
    accept    = (state == IDLE) && bus.start_i && !bus.annul_i;
    last_step = (cnt == CNT_W'(DIV_W - 1));
`ifdef MDU_DIV_EARLY_OUT_EN
    early_out = (bus.b_i != '0) && (a_mag < b_mag);
`else
    early_out = 1'b0;
`endif
  end

  div_radix2_step #(.DIV_W(DIV_W)) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (dvsr),
    .rem_next  (rem_step),
    .quot_next (quot_step)
  );

  // Sign fix on the final step's output. For 0x80000000 / -1 the quotient
  // magnitude is 0x80000000 and sign_q is 0, so it passes through unchanged.
  always_comb begin
    q_fix = (is_signed && sign_q) ? -quot_step : quot_step;
    r_fix = (is_signed && sign_r) ? -rem_step  : rem_step;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Annul outranks both hold and step completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = early_out ? DONE : BUSY;
      end
      BUSY: begin
        if (bus.annul_i)    state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE: begin
        if (bus.annul_i || !bus.hold_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      rem       <= '0;
      quot      <= '0;
      dvsr      <= '0;
      a_raw     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      is_signed <= 1'b0;
      div_zero  <= 1'b0;
      result    <= '0;
    end else if (accept) begin
      cnt       <= '0;
      rem       <= '0;
      quot      <= a_mag;
      dvsr      <= b_mag;
      a_raw     <= bus.a_i;
      sign_q    <= bus.a_i[DIV_W-1] ^ bus.b_i[DIV_W-1];
      sign_r    <= bus.a_i[DIV_W-1];
      is_signed <= bus.signed_i;
      div_zero  <= (bus.b_i == '0);
      if (early_out) result <= {bus.a_i, {DIV_W{1'b0}}};
    end else if (state == BUSY && !bus.annul_i) begin
      rem  <= rem_step;
      quot <= quot_step;
      cnt  <= cnt + 1'b1;
      if (last_step) begin
        result <= div_zero ? {a_raw, DZ_QUOT} : {r_fix, q_fix};
      end
    end
  end

  assign bus.result_o    = result;
  assign bus.ready_o     = (state == DONE);
  assign bus.busy_o      = (state == BUSY);
  assign bus.div_stall_o = accept || (state == BUSY);

endmodule

// File: doc/mdu_divider.md
Name: mdu_divider

Overview:
- Multi-cycle 32-bit divider in the EX stage; executes DIV and DIVU.
- Produces the `div_stall` request that the hazard unit ORs into `longest_stall`.
- Consumes the hazard unit's EX-stage stall (`hold_i`) and EX-stage flush (`annul_i`).
- Result goes to the HI/LO write path as {remainder, quotient}.

Parameters:
- DIV_W, 32, operand width; quotient and remainder are each DIV_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DIV_W.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start_i  input  1  EX-stage instruction is DIV/DIVU and valid.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- a_i  input  DIV_W  dividend (rs value after forwarding).
- b_i  input  DIV_W  divisor (rt value after forwarding).
- hold_i  input  1  EX stage frozen by another stall source (stallE).
- annul_i  input  1  EX-stage flush (flushE or exception); aborts the operation.
- result_o  output  2*DIV_W  {hi = remainder, lo = quotient}.
- ready_o  output  1  result_o valid for the instruction in EX.
- div_stall_o  output  1  stall request to the hazard unit.
- busy_o  output  1  state is BUSY.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (asynchronous, any state, including mid-division):
  - State goes to IDLE; counter cleared.
  - result_o = 0, ready_o = 0, busy_o = 0.
  - div_stall_o = 0 once start_i is low.
- IDLE:
  - Accept when start_i & ~annul_i, in cycle T.
  - On accept, latch: unsigned magnitudes |a| and |b| (magnitude taken only when signed_i); sign_q = a[31]^b[31]; sign_r = a[31]; the signed flag; a divide-by-zero flag (b == 0).
  - Go to BUSY with counter = 0.
- BUSY:
  - One restoring radix-2 step per cycle: shift {rem, quot} left by 1, trial-subtract the divisor, set quotient bit when the difference is non-negative.
  - Counter increments each cycle. After DIV_W steps (cycles T+1..T+32) go to DONE.
  - In the last step, register the final result into result_o.
- Sign fix, applied only when signed:
  - Quotient negated if sign_q.
  - Remainder negated if sign_r.
  - 0x80000000 / -1 yields lo = 0x80000000, hi = 0. No trap.
- Divide by zero: lo = all ones, hi = a_i as latched (raw); no sign fix.
- DONE:
  - ready_o = 1 (registered; first high at T+33).
  - Stay in DONE while hold_i. start_i is ignored here, so the same instruction never restarts.
  - Go to IDLE on ~hold_i.
- div_stall_o is combinational:
  - (IDLE & start_i & ~annul_i) | BUSY.
  - Default latency therefore: high in cycles T..T+32 (33 cycles), low in DONE.
- result_o holds its value until the next DONE load.
- annul_i:
  - In BUSY or DONE: next state IDLE, ready_o = 0 next cycle, result_o unchanged.
  - Takes priority over hold_i and over step completion.
- hold_i has no effect in IDLE or BUSY; BUSY keeps iterating.

Optional Feature:
- Macro: MDU_DIV_EARLY_OUT_EN.
- Defined, early-out case: on accept, if b != 0 and |a| < |b| (unsigned magnitudes), including a == 0:
  - Go straight to DONE at T+1.
  - result_o = {a_i, 0}: remainder is the original dividend, quotient 0.
  - div_stall_o is high only in cycle T.
- Undefined: every division takes the full DIV_W iterations.

Decomposition:
- Package mdu_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - DIV_W and CNT_W defaults.
  - RESULT_W = 2*DIV_W.
  - Divide-by-zero quotient constant (all ones).
- Sub-module div_radix2_step: combinational single iteration.
  - Inputs: {rem, quot}, divisor.
  - Output: next {rem, quot}.
  - Instantiated once, inside the BUSY datapath.

Test Plan:
- DIVU 100/7, start at T:
  - div_stall_o high T..T+32.
  - ready_o high at T+33.
  - lo = 14, hi = 2.
- DIV -7/2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- DIVU 5/0: lo = 0xFFFFFFFF, hi = 5. Cycle count identical to the normal case.
- annul_i at T+10:
  - State IDLE at T+11; div_stall_o low at T+11.
  - ready_o never asserts.
  - result_o retains its previous value.
  - A fresh start at T+12 is accepted.
- In DONE, hold_i high 4 cycles with start_i held high:
  - ready_o high 5 cycles; no restart.
  - IDLE after hold_i falls.
  - resetn pulsed mid-BUSY: all outputs 0 asynchronously.
  - With MDU_DIV_EARLY_OUT_EN, DIVU 3/7: ready_o at T+1, lo = 0, hi = 3.
